// File: rtl/wide_word_fifo.sv
// Small word FIFO behind the byte-duplicating front stage, with a saturating flagged-word count and a sticky byte-mismatch flag.
// Optional WIDE_WORD_FIFO_PARITY_EN adds a stored even-parity bit per entry and the out_par_err port.
module wide_word_fifo #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [15:0]              in_word,
    input  logic                     in_flag,
    output logic                     in_ready,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [15:0]              out_word,
    output logic                     out_flag,
    output logic [$clog2(DEPTH):0]   level,
    output logic [CNT_W-1:0]         flag_cnt,
    output logic                     dup_err
`ifdef WIDE_WORD_FIFO_PARITY_EN
    ,
    output logic                     out_par_err
`endif
);

    localparam int AW = $clog2(DEPTH);
`ifdef WIDE_WORD_FIFO_PARITY_EN
    localparam int EW = 18;
`else
    localparam int EW = 17;
`endif

    logic [EW-1:0] mem [DEPTH];
    logic [AW:0]   wptr;
    logic [AW:0]   rptr;
    logic [EW-1:0] entry_in;
    logic [EW-1:0] head;
    logic          full;
    logic          empty;
    logic          wr_en;
    logic          rd_en;

`ifdef WIDE_WORD_FIFO_PARITY_EN
    assign entry_in = {^{in_flag, in_word}, in_flag, in_word};
`else
    assign entry_in = {in_flag, in_word};
`endif

    // Extra pointer MSB separates full (laps differ) from empty (laps equal).
    assign empty     = (wptr == rptr);
    assign full      = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
    assign level     = wptr - rptr;
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign wr_en     = in_valid && in_ready;
    assign rd_en     = out_valid && out_ready;

    assign head     = mem[rptr[AW-1:0]];
    assign out_word = head[15:0];
    assign out_flag = head[16];

`ifdef WIDE_WORD_FIFO_PARITY_EN
    assign out_par_err = out_valid && (head[17] != ^{out_flag, out_word});
`endif

    // Storage is deliberately left unreset; head data is don't-care while empty.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wptr[AW-1:0]] <= entry_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr     <= '0;
            rptr     <= '0;
            flag_cnt <= '0;
            dup_err  <= 1'b0;
        end else begin
            if (wr_en) begin
                wptr <= wptr + (AW+1)'(1);
                if (in_flag && (flag_cnt != '1)) begin
                    flag_cnt <= flag_cnt + CNT_W'(1);
                end
                if (in_word[15:8] != in_word[7:0]) begin
                    dup_err <= 1'b1;
                end
            end
            if (rd_en) begin
                rptr <= rptr + (AW+1)'(1);
            end
        end
    end

endmodule

// File: tb/tb_wide_word_fifo.sv
// Bench for wide_word_fifo: directed steps plus random traffic against a queue-based model.
module tb_wide_word_fifo;
    localparam int DEPTH = 4;
    localparam int CNT_W = 8;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [15:0] in_word = '0;
    logic        in_flag = 1'b0;
    logic        out_ready = 1'b0;
    logic        in_ready, out_valid, out_flag, dup_err;
    logic [15:0] out_word;
    logic [2:0]  level;
    logic [CNT_W-1:0] flag_cnt;

    logic        out_ready2 = 1'b1;
    logic        in_ready2, out_valid2, out_flag2, dup_err2;
    logic [15:0] out_word2;
    logic [2:0]  level2;
    logic [1:0]  flag_cnt2;
`ifdef WIDE_WORD_FIFO_PARITY_EN
    logic        out_par_err, out_par_err2;
`endif

    always #5 clk = ~clk;

    wide_word_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_word(in_word), .in_flag(in_flag),
        .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
        .out_word(out_word), .out_flag(out_flag), .level(level),
        .flag_cnt(flag_cnt), .dup_err(dup_err)
`ifdef WIDE_WORD_FIFO_PARITY_EN
        , .out_par_err(out_par_err)
`endif
    );

    wide_word_fifo #(.DEPTH(DEPTH), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_word(in_word), .in_flag(in_flag),
        .in_ready(in_ready2), .out_valid(out_valid2), .out_ready(out_ready2),
        .out_word(out_word2), .out_flag(out_flag2), .level(level2),
        .flag_cnt(flag_cnt2), .dup_err(dup_err2)
`ifdef WIDE_WORD_FIFO_PARITY_EN
        , .out_par_err(out_par_err2)
`endif
    );

    int n_pass = 0;
    int n_total = 0;
    logic [16:0] q[$];
    int  m_cnt = 0;
    int  m_cnt2 = 0;
    bit  m_dup = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic check_all();
        chk("level", 32'(level), 32'(q.size()));
        chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
        chk("in_ready", 32'(in_ready), 32'(q.size() < DEPTH));
        chk("flag_cnt", 32'(flag_cnt), 32'(m_cnt));
        chk("dup_err", 32'(dup_err), 32'(m_dup));
        chk("flag_cnt2", 32'(flag_cnt2), 32'(m_cnt2));
        if (q.size() != 0) begin
            chk("out_word", 32'(out_word), 32'(q[0][15:0]));
            chk("out_flag", 32'(out_flag), 32'(q[0][16]));
        end
`ifdef WIDE_WORD_FIFO_PARITY_EN
        chk("out_par_err", 32'(out_par_err), 32'(0));
`endif
    endtask

    // Drive one cycle of inputs, then update the model with the handshakes that fired.
    task automatic cycle(input logic v, input logic [15:0] w, input logic f, input logic r);
        bit wr, rd;
        in_valid  = v;
        in_word   = w;
        in_flag   = f;
        out_ready = r;
        wr = v && (q.size() < DEPTH);
        rd = r && (q.size() != 0);
        @(posedge clk);
        #1;
        if (rd) void'(q.pop_front());
        if (wr) begin
            q.push_back({f, w});
            if (f && m_cnt < CMAX) m_cnt++;
            if (w[15:8] != w[7:0]) m_dup = 1'b1;
        end
        if (v && f && m_cnt2 < 3) m_cnt2++;
        check_all();
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        rst = 1'b1;
        q.delete();
        m_cnt = 0;
        m_cnt2 = 0;
        m_dup = 1'b0;
        #2;
        chk("rst_out_valid", 32'(out_valid), 32'(0));
        chk("rst_level", 32'(level), 32'(0));
        chk("rst_in_ready", 32'(in_ready), 32'(1));
        chk("rst_dup_err", 32'(dup_err), 32'(0));
        chk("rst_flag_cnt", 32'(flag_cnt), 32'(0));
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0]  b;
        logic [15:0] w;

        #3;
        do_reset();
        check_all();

        cycle(1'b1, 16'hA5A5, 1'b1, 1'b0);
        chk("a5_word", 32'(out_word), 32'h0000A5A5);
        chk("a5_cnt", 32'(flag_cnt), 32'd1);
        cycle(1'b0, 16'h0000, 1'b0, 1'b1);

        cycle(1'b1, 16'h1111, 1'b0, 1'b0);
        cycle(1'b1, 16'h2222, 1'b0, 1'b0);
        cycle(1'b1, 16'h3333, 1'b0, 1'b0);
        cycle(1'b1, 16'h4444, 1'b0, 1'b0);
        chk("full_level", 32'(level), 32'd4);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        cycle(1'b1, 16'h5555, 1'b0, 1'b0);
        chk("fifth_dropped_level", 32'(level), 32'd4);
        for (int i = 0; i < 4; i++) cycle(1'b0, 16'h0000, 1'b0, 1'b1);
        chk("drained", 32'(out_valid), 32'd0);

        for (int i = 1; i <= 4; i++) cycle(1'b1, 16'(i * 16'h1111), 1'b0, 1'b0);
        cycle(1'b1, 16'h5555, 1'b1, 1'b1);
        chk("full_rw_level", 32'(level), 32'd3);
        cycle(1'b1, 16'h5555, 1'b1, 1'b0);
        chk("full_rw_refill", 32'(level), 32'd4);
        for (int i = 0; i < 5; i++) cycle(1'b0, 16'h0000, 1'b0, 1'b1);

        cycle(1'b1, 16'h12FF, 1'b0, 1'b1);
        chk("dup_rise", 32'(dup_err), 32'd1);
        for (int i = 0; i < 10; i++) cycle(1'b1, 16'(i * 16'h0101), 1'b0, 1'b1);
        chk("dup_sticky", 32'(dup_err), 32'd1);

        do_reset();
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, 16'h8080, 1'b1, 1'b1);
            chk("cnt2_seq", 32'(flag_cnt2), 32'((i + 1 > 3) ? 3 : i + 1));
        end

        do_reset();
        for (int i = 0; i < 400; i++) begin
            b = 8'($urandom);
            w = ($urandom_range(0, 29) == 0) ? 16'($urandom) : {b, b};
            cycle(1'($urandom_range(0, 2) != 0), w, b[7], 1'($urandom_range(0, 1)));
        end

        do_reset();
        cycle(1'b1, 16'h0101, 1'b0, 1'b0);
        cycle(1'b1, 16'h0202, 1'b0, 1'b0);
        cycle(1'b1, 16'h0303, 1'b1, 1'b0);
        chk("pre_rst_level", 32'(level), 32'd3);
        do_reset();
        cycle(1'b1, 16'h0707, 1'b0, 1'b0);
        chk("post_rst_head", 32'(out_word), 32'h00000707);
        cycle(1'b0, 16'h0000, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/wide_word_fifo.md
# wide_word_fifo

- Downstream neighbour of the byte-duplicating front stage.
- Captures each 16-bit word and its flag bit into a small FIFO.
- Presents entries to the next consumer over a valid/ready handshake.
- Keeps a saturating count of flagged words for status readout.

## Interface
- `DEPTH`, 4: number of FIFO entries; power of two, 2..16.
- `CNT_W`, 8: width of the flagged-word counter.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: upstream word valid this cycle.
- `in_word` in 16: upstream word; the front stage supplies `{byte, byte}`.
- `in_flag` in 1: upstream flag; the MSB of the upper nibble of the byte.
- `in_ready` out 1: FIFO can accept; equals `!full`.
- `out_valid` out 1: head entry is available.
- `out_ready` in 1: consumer accepts the head entry.
- `out_word` out 16: head entry word.
- `out_flag` out 1: head entry flag.
- `level` out `$clog2(DEPTH)+1`: current occupancy.
- `flag_cnt` out `CNT_W`: saturating count of flagged words written.
- `dup_err` out 1: sticky; set when a written word has `in_word[15:8] != in_word[7:0]`.

## Operation
- Storage: `DEPTH` entries of {flag, word}.
  - Write pointer and read pointer each have `$clog2(DEPTH)+1` bits; the extra MSB distinguishes full from empty.
  - Pointers wrap modulo `2*DEPTH`.
- Write:
  - Occurs when `in_valid && in_ready`.
  - Stores {`in_flag`, `in_word`} at `wptr[low bits]` and increments `wptr`.
- Read:
  - Occurs when `out_valid && out_ready`.
  - Increments `rptr`.
  - `out_word`/`out_flag` are driven combinationally from `mem[rptr[low bits]]`.
- Status:
  - `empty = (wptr == rptr)`.
  - `full = low bits equal && MSBs differ`.
  - `level = wptr - rptr`.
- Simultaneous write and read:
  - When not full and not empty, both occur and `level` is unchanged.
  - When empty, only the write occurs; the new word appears at the head the next cycle. There is no bypass.
  - When full, `in_ready` = 0, so only the read occurs. The freed slot is available on the following cycle; `in_ready` does not depend combinationally on `out_ready`.
- `flag_cnt`:
  - Increments on each write with `in_flag` = 1.
  - Holds at `2^CNT_W-1` once reached; no wrap.
- `dup_err`:
  - Set on a write whose two bytes differ.
  - Stays high until `rst`.
- Ignored inputs:
  - `in_valid` while full: word dropped by protocol; upstream must hold it.
  - `out_ready` while empty: no effect.

## Timing
- Reset values, applied asynchronously on `rst` high:
  - `wptr` = `rptr` = 0, so `level` = 0 and `out_valid` = 0, `in_ready` = 1.
  - `flag_cnt` = 0, `dup_err` = 0.
  - Memory contents are not reset; `out_word`/`out_flag` are don't-care while `out_valid` = 0.
- Latency: 1 cycle from write edge to `out_valid` on an empty FIFO.
- Throughput: one word per cycle sustained when neither full nor empty.
- Handshake rules:
  - `out_valid` and the head data stay stable until accepted.
  - `out_valid` never drops without a read, except on `rst`.
- Reset mid-operation:
  - All entries are discarded immediately.
  - Words in flight are lost.
  - The first write after `rst` deasserts lands in entry 0.

## Configuration
- `WIDE_WORD_FIFO_PARITY_EN` defined:
  - Each entry stores an extra even-parity bit computed as `^{in_flag, in_word}` at write.
  - Adds port `out_par_err` out 1, high while `out_valid` and the stored parity mismatches `^{out_flag, out_word}`.
  - `out_par_err` resets to 0.
- Not defined: no parity storage, and port `out_par_err` does not exist.

## Test plan
- Reset, then write `16'hA5A5` flag=1 with `out_ready`=0:
  - After 1 cycle, `out_valid`=1, `out_word`=`A5A5`, `out_flag`=1, `level`=1, `flag_cnt`=1.
- Fill with `DEPTH`=4 writes `1111`, `2222`, `3333`, `4444`:
  - `in_ready`=0 and `level`=4.
  - A fifth word presented is not stored.
  - Drain returns 1111..4444 in order.
- Full, with `in_valid`=1 and `out_ready`=1 together:
  - Cycle 1: read only, `level`=3.
  - Next cycle: write accepted, `level`=4.
  - Order preserved.
- Write word `16'h12FF`:
  - `dup_err` rises the next cycle and stays 1 through 10 further matched writes.
  - Cleared only by `rst`.
- `CNT_W`=2, six writes with flag=1:
  - `flag_cnt` reads 1, 2, 3, 3, 3, 3.
- Assert `rst` with 3 entries queued:
  - `out_valid`=0 and `level`=0 immediately, without a clock edge.
  - After release, a write of `0707` is read back first.
  - With the parity macro defined, `out_par_err`=0 throughout.
